reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order, retire one done head entry per cycle.
// Commit follows completion of the head by one cycle; alloc_ready drops only when all DEPTH entries are occupied.
`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 32
`endif

module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int D_AW  = $clog2(`NUM_D_REG),
  parameter int S_AW  = $clog2(`NUM_S_REG)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     alloc_valid,
  input  logic                     alloc_use_rw,
  input  logic                     alloc_use_rs,
  input  logic [D_AW-1:0]          alloc_prev_rw_addr,
  input  logic [S_AW-1:0]          alloc_prev_rs_addr,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     complete_valid,
  input  logic [$clog2(DEPTH)-1:0] complete_tag,
  input  logic                     flush,
  output logic                     commit_valid,
  output logic                     commit_use_rw,
  output logic                     commit_use_rs,
  output logic [D_AW-1:0]          commit_prev_rw_addr,
  output logic [S_AW-1:0]          commit_prev_rs_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_use_rw;
  logic [DEPTH-1:0] ent_use_rs;
  logic [D_AW-1:0]  ent_prev_rw [DEPTH];
  logic [S_AW-1:0]  ent_prev_rs [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_alloc;
  logic             do_complete;

  assign alloc_ready = (count != (AW+1)'(DEPTH));
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid & alloc_ready & ~flush;
  assign do_complete = complete_valid & ~flush & ent_valid[complete_tag];

  assign commit_valid        = ent_valid[head] & ent_done[head] & ~flush;
  assign commit_use_rw       = ent_use_rw[head] & commit_valid;
  assign commit_use_rs       = ent_use_rs[head] & commit_valid;
  assign commit_prev_rw_addr = ent_prev_rw[head];
  assign commit_prev_rs_addr = ent_prev_rs[head];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ent_valid  <= '0;
      ent_done   <= '0;
      ent_use_rw <= '0;
      ent_use_rs <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_prev_rw[i] <= '0;
        ent_prev_rs[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (do_alloc) begin
        ent_valid[tail]   <= 1'b1;
        ent_done[tail]    <= 1'b0;
        ent_use_rw[tail]  <= alloc_use_rw;
        ent_use_rs[tail]  <= alloc_use_rs;
        ent_prev_rw[tail] <= alloc_prev_rw_addr;
        ent_prev_rs[tail] <= alloc_prev_rs_addr;
        tail              <= tail + AW'(1);
      end
      if (do_complete) begin
        ent_done[complete_tag] <= 1'b1;
      end
      // Retirement clears the head last so it wins over a redundant complete to the same entry.
      if (commit_valid) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + AW'(1);
      end
      case ({do_alloc, commit_valid})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
